// File: rtl/nes_multi_pad_reader.sv
// Serial NES/SNES pad reader: drives a shared latch/clock pair, shifts all pads in parallel
// and publishes active-low button vectors with press/release event pulses.
module nes_multi_pad_reader #(
   parameter int NUM_PADS         = 2,
   parameter int NUM_BUTTONS      = 8,
   parameter int CLK_DIV          = 300,
   parameter int AUTO_POLL_CYCLES = 0
) (
   input  logic                            in_clock,
   input  logic                            reset_n,
   input  logic [NUM_PADS-1:0]             pad_data,
   input  logic                            read_data,
   output logic                            pad_latch,
   output logic                            pad_clock,
   output logic [NUM_PADS*NUM_BUTTONS-1:0] buttons,
   output logic [NUM_PADS*NUM_BUTTONS-1:0] pressed,
   output logic [NUM_PADS*NUM_BUTTONS-1:0] released,
   output logic                            buttons_valid,
   output logic                            ready_to_read
);

   localparam int TOTAL = NUM_PADS * NUM_BUTTONS;
   localparam int DIV_W = $clog2(2 * CLK_DIV + 1);
   localparam int IDX_W = (NUM_BUTTONS > 1) ? $clog2(NUM_BUTTONS) : 1;
   localparam logic [DIV_W-1:0] LATCH_LAST = DIV_W'(2 * CLK_DIV - 1);
   localparam logic [DIV_W-1:0] HALF_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_BUTTONS - 1);

   typedef enum logic [2:0] {IDLE, LATCH, GAP, CLK_HI, DONE} state_t;

   state_t             state;
   state_t             next_state;
   logic [DIV_W-1:0]   div_cnt;
   logic [IDX_W-1:0]   bit_idx;
   logic [TOTAL-1:0]   shift_reg;
   logic               pending;
   logic               poll_wrap;
   logic               start;
   logic               phase_end;
   logic               last_bit;
   logic               latch_next;
   logic               clock_next;

   assign start     = (state == IDLE) && (read_data || pending);
   assign phase_end = (state == LATCH) ? (div_cnt == LATCH_LAST) : (div_cnt == HALF_LAST);
   assign last_bit  = (bit_idx == IDX_LAST);

   always_ff @(posedge in_clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start)     next_state = LATCH;
         LATCH:   if (phase_end) next_state = GAP;
         GAP:     if (phase_end) next_state = last_bit ? DONE : CLK_HI;
         CLK_HI:  if (phase_end) next_state = GAP;
         DONE:                   next_state = IDLE;
         default:                next_state = IDLE;
      endcase
   end

   // Pin levels are decoded from the next state so the registered pins line up with the state
   always_comb begin
      latch_next    = (next_state == LATCH);
      clock_next    = (next_state == CLK_HI);
      ready_to_read = (state == IDLE);
   end

   always_ff @(posedge in_clock or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt   <= '0;
         bit_idx   <= '0;
         shift_reg <= '1;
      end else begin
         if ((state == IDLE) || (next_state != state)) begin
            div_cnt <= '0;
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end

         if (start) begin
            bit_idx <= '0;
         end else if ((state == GAP) && phase_end && !last_bit) begin
            bit_idx <= bit_idx + 1'b1;
         end

         if ((state == GAP) && phase_end) begin
            for (int p = 0; p < NUM_PADS; p++) begin
               shift_reg[p * NUM_BUTTONS + int'(bit_idx)] <= pad_data[p];
            end
         end
      end
   end

   always_ff @(posedge in_clock or negedge reset_n) begin
      if (!reset_n) begin
         pad_latch     <= 1'b0;
         pad_clock     <= 1'b0;
         buttons       <= '1;
         pressed       <= '0;
         released      <= '0;
         buttons_valid <= 1'b0;
      end else begin
         pad_latch <= latch_next;
         pad_clock <= clock_next;
         if (state == DONE) begin
            buttons       <= shift_reg;
            pressed       <= buttons & ~shift_reg;
            released      <= ~buttons & shift_reg;
            buttons_valid <= 1'b1;
         end else begin
            pressed       <= '0;
            released      <= '0;
            buttons_valid <= 1'b0;
         end
      end
   end

   // A wrap on the same edge a frame starts re-arms pending, so that request is not lost
   always_ff @(posedge in_clock or negedge reset_n) begin
      if (!reset_n) begin
         pending <= 1'b0;
      end else if (poll_wrap) begin
         pending <= 1'b1;
      end else if (start) begin
         pending <= 1'b0;
      end
   end

   if (AUTO_POLL_CYCLES > 0) begin : g_poll
      localparam int POLL_W = (AUTO_POLL_CYCLES > 1) ? $clog2(AUTO_POLL_CYCLES) : 1;
      localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(AUTO_POLL_CYCLES - 1);
      logic [POLL_W-1:0] poll_cnt;

      always_ff @(posedge in_clock or negedge reset_n) begin
         if (!reset_n) begin
            poll_cnt <= '0;
         end else if (poll_cnt == POLL_LAST) begin
            poll_cnt <= '0;
         end else begin
            poll_cnt <= poll_cnt + 1'b1;
         end
      end

      assign poll_wrap = (poll_cnt == POLL_LAST);
   end else begin : g_no_poll
      assign poll_wrap = 1'b0;
   end

endmodule

// File: tb/tb_nes_multi_pad_reader.sv
// Scoreboard bench for nes_multi_pad_reader: two modelled pads on a request-driven instance,
// plus two auto-poll instances (100 and 50 cycles) fed constant data lines.
module tb_nes_multi_pad_reader;

   logic        in_clock;
   logic        reset_n;
   logic        rst_auto;
   logic        read_data;
   logic [1:0]  pad_data;
   logic        pad_latch;
   logic        pad_clock;
   logic [15:0] buttons;
   logic [15:0] pressed;
   logic [15:0] released;
   logic        buttons_valid;
   logic        ready_to_read;

   logic        a100_latch, a100_clock, a100_valid, a100_ready;
   logic [15:0] a100_buttons, a100_pressed, a100_released;
   logic        a50_latch, a50_clock, a50_valid, a50_ready;
   logic [15:0] a50_buttons, a50_pressed, a50_released;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      logic [15:0] b;
      logic [15:0] p;
      logic [15:0] r;
      int          e0;
   } exp_t;
   exp_t sb[$];

   logic [15:0] model_prev;
   logic [7:0]  pad0_val, pad1_val;
   logic [7:0]  sr0, sr1;
   logic        pclk_d;

   nes_multi_pad_reader #(.NUM_PADS(2), .NUM_BUTTONS(8), .CLK_DIV(4), .AUTO_POLL_CYCLES(0)) dut (
      .in_clock(in_clock), .reset_n(reset_n), .pad_data(pad_data), .read_data(read_data),
      .pad_latch(pad_latch), .pad_clock(pad_clock), .buttons(buttons), .pressed(pressed),
      .released(released), .buttons_valid(buttons_valid), .ready_to_read(ready_to_read));

   nes_multi_pad_reader #(.NUM_PADS(2), .NUM_BUTTONS(8), .CLK_DIV(4), .AUTO_POLL_CYCLES(100)) dut_a100 (
      .in_clock(in_clock), .reset_n(rst_auto), .pad_data(2'b10), .read_data(1'b0),
      .pad_latch(a100_latch), .pad_clock(a100_clock), .buttons(a100_buttons), .pressed(a100_pressed),
      .released(a100_released), .buttons_valid(a100_valid), .ready_to_read(a100_ready));

   nes_multi_pad_reader #(.NUM_PADS(2), .NUM_BUTTONS(8), .CLK_DIV(4), .AUTO_POLL_CYCLES(50)) dut_a50 (
      .in_clock(in_clock), .reset_n(rst_auto), .pad_data(2'b10), .read_data(1'b0),
      .pad_latch(a50_latch), .pad_clock(a50_clock), .buttons(a50_buttons), .pressed(a50_pressed),
      .released(a50_released), .buttons_valid(a50_valid), .ready_to_read(a50_ready));

   initial in_clock = 1'b0;
   always #5 in_clock = ~in_clock;

   always @(posedge in_clock) cyc <= cyc + 1;

   // 4021-style pad: parallel load while latched, shift toward bit 0 on each pad_clock rise
   always @(posedge in_clock) begin
      if (pad_latch) begin
         sr0 <= pad0_val;
         sr1 <= pad1_val;
      end else if (pad_clock && !pclk_d) begin
         sr0 <= {1'b1, sr0[7:1]};
         sr1 <= {1'b1, sr1[7:1]};
      end
      pclk_d <= pad_clock;
   end
   assign pad_data = {sr1[0], sr0[0]};

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   int  lat_cnt   = 0;
   int  pulse_cnt = 0;
   logic clk_prev = 1'b0;
   logic valid_d  = 1'b0;

   always @(negedge in_clock) begin
      exp_t e;
      if (!reset_n) begin
         lat_cnt   = 0;
         pulse_cnt = 0;
      end else begin
         if (pad_latch) lat_cnt++;
         if (pad_clock && !clk_prev) pulse_cnt++;
      end
      clk_prev = pad_clock;

      if (valid_d) begin
         checkOutput("valid_width", {31'd0, buttons_valid}, 32'd0);
         checkOutput("pressed_cleared", {16'd0, pressed | released}, 32'd0);
      end
      valid_d = buttons_valid;

      if (buttons_valid) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_valid at cycle %0d buttons=%h", cyc, buttons);
         end else begin
            e = sb.pop_front();
            checkOutput("buttons", {16'd0, buttons}, {16'd0, e.b});
            checkOutput("pressed", {16'd0, pressed}, {16'd0, e.p});
            checkOutput("released", {16'd0, released}, {16'd0, e.r});
            checkOutput("latency", cyc, e.e0 + 69);
            checkOutput("latch_cycles", lat_cnt, 8);
            checkOutput("clock_pulses", pulse_cnt, 7);
            checkOutput("ready_after_done", {31'd0, ready_to_read}, 32'd1);
         end
         lat_cnt   = 0;
         pulse_cnt = 0;
      end
   end

   int a100_cnt = 0, a100_last = 0;
   int a50_cnt  = 0, a50_last  = 0;

   always @(negedge in_clock) begin
      if (a100_valid) begin
         checkOutput("a100_buttons", {16'd0, a100_buttons}, 32'h0000_FF00);
         checkOutput("a100_pressed", {16'd0, a100_pressed}, (a100_cnt == 0) ? 32'h0000_00FF : 32'd0);
         checkOutput("a100_released", {16'd0, a100_released}, 32'd0);
         if (a100_cnt > 0) checkOutput("a100_interval", cyc - a100_last, 100);
         a100_last = cyc;
         a100_cnt++;
      end
      if (a50_valid) begin
         checkOutput("a50_buttons", {16'd0, a50_buttons}, 32'h0000_FF00);
         if (a50_cnt > 0) checkOutput("a50_interval", cyc - a50_last, 70);
         a50_last = cyc;
         a50_cnt++;
      end
   end

   // Issues one request; when expectFrame is set the scoreboard entry is pushed and the frame awaited
   task automatic applyStimulus(input logic [7:0] p0, input logic [7:0] p1,
                                input bit expectFrame, input bit extraReads, output int e0);
      exp_t        e;
      logic [15:0] nv;
      int          n;
      pad0_val = p0;
      pad1_val = p1;
      @(negedge in_clock);
      read_data = 1'b1;
      e0 = cyc + 1;
      if (expectFrame) begin
         nv   = {p1, p0};
         e.b  = nv;
         e.p  = model_prev & ~nv;
         e.r  = ~model_prev & nv;
         e.e0 = e0;
         sb.push_back(e);
         model_prev = nv;
      end
      @(negedge in_clock);
      read_data = 1'b0;
      checkOutput("ready_low", {31'd0, ready_to_read}, 32'd0);
      if (extraReads) begin
         while (cyc < e0 + 19) @(negedge in_clock);
         read_data = 1'b1;
         @(negedge in_clock);
         read_data = 1'b0;
         while (cyc < e0 + 39) @(negedge in_clock);
         read_data = 1'b1;
         checkOutput("ready_low_mid", {31'd0, ready_to_read}, 32'd0);
         @(negedge in_clock);
         read_data = 1'b0;
      end
      if (expectFrame) begin
         n = 0;
         while (sb.size() != 0 && n < 200) begin
            @(negedge in_clock);
            n++;
         end
         if (sb.size() != 0) checkOutput("frame_timeout", sb.size(), 0);
         repeat (3) @(negedge in_clock);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int e0;
      int n;
      reset_n    = 1'b0;
      rst_auto   = 1'b0;
      read_data  = 1'b0;
      pad0_val   = 8'hFF;
      pad1_val   = 8'hFF;
      model_prev = 16'hFFFF;
      repeat (3) @(negedge in_clock);
      reset_n  = 1'b1;
      rst_auto = 1'b1;
      repeat (5) @(negedge in_clock);

      $display("[TB] reset while idle");
      reset_n = 1'b0;
      repeat (2) @(negedge in_clock);
      reset_n = 1'b1;
      @(negedge in_clock);
      checkOutput("rst_buttons", {16'd0, buttons}, 32'h0000_FFFF);
      checkOutput("rst_events", {16'd0, pressed | released}, 32'd0);
      checkOutput("rst_valid", {31'd0, buttons_valid}, 32'd0);
      checkOutput("rst_ready", {31'd0, ready_to_read}, 32'd1);
      checkOutput("rst_pins", {30'd0, pad_latch, pad_clock}, 32'd0);

      $display("[TB] basic reads");
      applyStimulus(8'hFE, 8'h7F, 1'b1, 1'b0, e0);
      applyStimulus(8'hFE, 8'h7F, 1'b1, 1'b0, e0);
      applyStimulus(8'hFF, 8'h7F, 1'b1, 1'b0, e0);

      $display("[TB] requests during a frame");
      applyStimulus(8'h00, 8'hFF, 1'b1, 1'b1, e0);

      $display("[TB] reset mid-frame");
      applyStimulus(8'h12, 8'h34, 1'b0, 1'b0, e0);
      while (cyc < e0 + 29) @(negedge in_clock);
      checkOutput("clk_before_reset", {31'd0, pad_clock}, 32'd1);
      reset_n = 1'b0;
      #1;
      checkOutput("abort_pins", {30'd0, pad_latch, pad_clock}, 32'd0);
      checkOutput("abort_buttons", {16'd0, buttons}, 32'h0000_FFFF);
      checkOutput("abort_valid", {31'd0, buttons_valid}, 32'd0);
      checkOutput("abort_ready", {31'd0, ready_to_read}, 32'd1);
      model_prev = 16'hFFFF;
      repeat (3) @(negedge in_clock);
      reset_n = 1'b1;
      repeat (80) @(negedge in_clock);
      checkOutput("abort_no_update", {16'd0, buttons}, 32'h0000_FFFF);
      applyStimulus(8'hA5, 8'h3C, 1'b1, 1'b0, e0);

      $display("[TB] waiting for auto-poll instances");
      n = 0;
      while ((a100_cnt < 4 || a50_cnt < 5) && n < 2000) begin
         @(negedge in_clock);
         n++;
      end
      if (a100_cnt < 4) checkOutput("a100_count", a100_cnt, 4);
      if (a50_cnt < 5) checkOutput("a50_count", a50_cnt, 5);
      checkOutput("sb_empty", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/nes_multi_pad_reader.md
Name: nes_multi_pad_reader

Overview:
Parametrised serial game-pad reader for NES (8-bit) and SNES (16-bit) pads, with NUM_PADS pads sharing one latch and one clock line. Generates the latch and clock waveforms from a programmable divider and samples every pad's data line in parallel. Publishes active-low button vectors plus per-button press/release event pulses and a one-cycle valid strobe. A frame starts either on a read_data request or from an optional built-in auto-poll timer. Sits between the pad connector pins and game/control logic.

Parameters:
NUM_PADS, 2, number of pads (data inputs); >=1
NUM_BUTTONS, 8, bits shifted per pad (8 NES, 16 SNES); >=1
CLK_DIV, 300, in_clock cycles per half pad-clock period (6 us at 50 MHz); >=1
AUTO_POLL_CYCLES, 0, 0 = auto-poll off; else a frame is requested every AUTO_POLL_CYCLES in_clock cycles

Ports:
in_clock  in  1  system clock; all logic on rising edge
reset_n  in  1  reset
pad_data  in  NUM_PADS  serial data from each pad, active-low, externally synchronised
read_data  in  1  frame request, sampled every cycle
pad_latch  out  1  shared latch to pads
pad_clock  out  1  shared shift clock to pads
buttons  out  NUM_PADS*NUM_BUTTONS  last completed frame; bit p*NUM_BUTTONS+b = bit b of pad p; 0 = pressed
pressed  out  NUM_PADS*NUM_BUTTONS  one-cycle pulse per button going released->pressed
released  out  NUM_PADS*NUM_BUTTONS  one-cycle pulse per button going pressed->released
buttons_valid  out  1  one-cycle strobe: buttons/pressed/released updated
ready_to_read  out  1  high only in IDLE

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (reset_n low, immediate): state IDLE, pad_latch 0, pad_clock 0, buttons all 1, pressed 0, released 0, buttons_valid 0, ready_to_read 1, poll counter 0, pending 0. Reset mid-frame aborts the frame; partial data is discarded and buttons is not updated.
- Let C = CLK_DIV and N = NUM_BUTTONS.
- State machine states: IDLE, LATCH, GAP, CLK_HI, DONE.
- IDLE: if read_data or pending is high at edge E0, go to LATCH and clear pending and the bit index.
- LATCH: pad_latch = 1 for 2C cycles, then go to GAP.
- GAP: latch and clock both 0 for C cycles.
  - On the last GAP cycle, pad_data[p] is sampled into the shift register at shift[p][bit_idx] for every pad.
  - If bit_idx = N-1, go to DONE; otherwise increment bit_idx and go to CLK_HI.
- CLK_HI: pad_clock = 1 for C cycles, then go to GAP. This gives N-1 clock pulses per frame.
- DONE: one cycle, then go to IDLE. At the exit edge:
  - buttons <= new frame
  - pressed <= old & ~new
  - released <= ~old & new
  - buttons_valid <= 1
- pressed, released and buttons_valid are all cleared on the following edge.
- Latency: buttons_valid is high in the cycle after edge E0 + (2N+1)C + 1. For N = 8, C = 4 that is edge 69.
- Pin outputs pad_latch and pad_clock are registered (glitch-free).
- Divider counter width is clog2(2C+1). bit_idx width is clog2(N), minimum 1.
- read_data while not IDLE is ignored; there is no queuing and no frame restart.
- Auto-poll (AUTO_POLL_CYCLES > 0):
  - The free-running counter wraps at AUTO_POLL_CYCLES-1 and sets pending on wrap.
  - Pending holds until the next IDLE; at most one request is pending.
  - A simultaneous read_data and pending start one frame.
  - With AUTO_POLL_CYCLES = 0 the counter is removed and pending stays 0.
- A disconnected pad reads all 1s (pull-ups), i.e. all released; no special handling.
- NES bit order b = 0..7: A, B, Select, Start, Up, Down, Left, Right.

Test Plan:
1. Assert reset_n low mid-idle and release it -> buttons = 16'hFFFF, pressed/released/valid = 0, ready_to_read = 1, latch/clock = 0 (NUM_PADS = 2, N = 8, C = 4).
2. Pad models drive pad0 = 8'hFE and pad1 = 8'h7F; pulse read_data at E0 -> pad_latch high 8 cycles; 7 pad_clock pulses of 4 cycles; buttons_valid one cycle at edge 69; buttons = 16'h7FFE; pressed = 16'h8001; released = 0.
3. Repeat the read with identical data -> pressed = released = 0. Then set pad0 = 8'hFF and read -> released = 16'h0001, buttons = 16'h7FFF.
4. Start a frame, then pulse read_data at cycles 20 and 40 -> exactly one buttons_valid; ready_to_read low from E0+1 until after DONE.
5. Pull reset_n low at cycle 30 mid-frame -> latch/clock drop immediately; buttons stay 16'hFFFF; no valid pulse. After release, a new read returns correct data.
6. Set AUTO_POLL_CYCLES = 100 and never drive read_data -> buttons_valid every 100 cycles. With AUTO_POLL_CYCLES = 50 (shorter than a 69-cycle frame) -> back-to-back frames, no lost or duplicate valid pulses.
